// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: op codes, load-select
// bit positions (the same ones WB decodes), bus size codes and FSM states.
package mem_access_stage_pkg;

   typedef enum logic [3:0] {
      MEM_OP_NONE = 4'd0,
      MEM_OP_LB   = 4'd1,
      MEM_OP_LBU  = 4'd2,
      MEM_OP_LH   = 4'd3,
      MEM_OP_LHU  = 4'd4,
      MEM_OP_LW   = 4'd5,
      MEM_OP_LWL  = 4'd6,
      MEM_OP_LWR  = 4'd7,
      MEM_OP_SB   = 4'd8,
      MEM_OP_SH   = 4'd9,
      MEM_OP_SW   = 4'd10,
      MEM_OP_SWL  = 4'd11,
      MEM_OP_SWR  = 4'd12
   } mem_op_e;

   localparam int LOAD_SEL_W = 11;
   localparam int LOAD_LB    = 0;
   localparam int LOAD_LBU   = 1;
   localparam int LOAD_LH    = 2;
   localparam int LOAD_LHU   = 3;
   localparam int LOAD_LW    = 4;
   localparam int LOAD_L0    = 5;
   localparam int LOAD_L1    = 6;
   localparam int LOAD_L2    = 7;
   localparam int LOAD_R1    = 8;
   localparam int LOAD_R2    = 9;
   localparam int LOAD_R3    = 10;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   function automatic logic is_load(mem_op_e op);
      return (op >= MEM_OP_LB) && (op <= MEM_OP_LWR);
   endfunction

   function automatic logic is_store(mem_op_e op);
      return (op >= MEM_OP_SB) && (op <= MEM_OP_SWR);
   endfunction

   // Unaligned LWL/LWR/SWL/SWR are legal by design and never fault.
   function automatic logic addr_err(mem_op_e op, logic [1:0] a);
      case (op)
         MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: addr_err = a[0];
         MEM_OP_LW, MEM_OP_SW:             addr_err = |a;
         default:                          addr_err = 1'b0;
      endcase
   endfunction

   function automatic logic is_partial_word(mem_op_e op);
      return (op == MEM_OP_LWL) || (op == MEM_OP_LWR) ||
             (op == MEM_OP_SWL) || (op == MEM_OP_SWR);
   endfunction

endpackage

// File: rtl/mem_access_stage_store_align.sv
// Combinational lane logic: byte enables, lane-aligned store data, bus size,
// address-error detection and the one-hot load select handed to WB.
module mem_store_align
   import mem_access_stage_pkg::*;
(
   input  mem_op_e                 op,
   input  logic [1:0]              a,
   input  logic [31:0]             rt,
   output logic [3:0]              wstrb,
   output logic [31:0]             wdata,
   output logic [1:0]              size,
   output logic                    addrErr,
   output logic [LOAD_SEL_W-1:0]   loadSel
);

   always_comb begin
      wstrb   = 4'b0000;
      wdata   = 32'h0;
      size    = SIZE_BYTE;
      loadSel = '0;
      addrErr = addr_err(op, a);
      case (op)
         MEM_OP_LB:  loadSel[LOAD_LB] = 1'b1;
         MEM_OP_LBU: loadSel[LOAD_LBU] = 1'b1;
         MEM_OP_LH: begin
            size = SIZE_HALF;
            loadSel[LOAD_LH] = 1'b1;
         end
         MEM_OP_LHU: begin
            size = SIZE_HALF;
            loadSel[LOAD_LHU] = 1'b1;
         end
         MEM_OP_LW: begin
            size = SIZE_WORD;
            loadSel[LOAD_LW] = 1'b1;
         end
         MEM_OP_LWL: begin
            size = SIZE_WORD;
            case (a)
               2'd0:    loadSel[LOAD_L0] = 1'b1;
               2'd1:    loadSel[LOAD_L1] = 1'b1;
               2'd2:    loadSel[LOAD_L2] = 1'b1;
               default: loadSel[LOAD_LW] = 1'b1;
            endcase
         end
         MEM_OP_LWR: begin
            size = SIZE_WORD;
            case (a)
               2'd0:    loadSel[LOAD_LW] = 1'b1;
               2'd1:    loadSel[LOAD_R1] = 1'b1;
               2'd2:    loadSel[LOAD_R2] = 1'b1;
               default: loadSel[LOAD_R3] = 1'b1;
            endcase
         end
         MEM_OP_SB: begin
            wstrb = 4'b0001 << a;
            wdata = {4{rt[7:0]}};
         end
         MEM_OP_SH: begin
            size  = SIZE_HALF;
            wstrb = a[1] ? 4'b1100 : 4'b0011;
            wdata = {2{rt[15:0]}};
         end
         MEM_OP_SW: begin
            size  = SIZE_WORD;
            wstrb = 4'b1111;
            wdata = rt;
         end
         MEM_OP_SWL: begin
            // 3-a equals ~a for a two-bit offset.
            size = SIZE_WORD;
            case (a)
               2'd0:    wstrb = 4'b0001;
               2'd1:    wstrb = 4'b0011;
               2'd2:    wstrb = 4'b0111;
               default: wstrb = 4'b1111;
            endcase
            wdata = rt >> {~a, 3'b000};
         end
         MEM_OP_SWR: begin
            size  = SIZE_WORD;
            wstrb = 4'b1111 << a;
            wdata = rt << {a, 3'b000};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: holds one EXE entry, issues at most one data
// request for it and passes load select / alignment / rt data on to WB.
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_w_i,
   input  logic                  EXE_valid_w_i,
   input  logic                  WB_allowin_w_i,
   output logic                  MEM_allowin_w_o,
   output logic                  MEM_valid_w_o,
   input  logic [4:0]            EXE_writeNum_i,
   input  logic [ADDR_W-1:0]     EXE_VAddr_i,
   input  logic [ADDR_W-1:0]     EXE_memAddr_i,
   input  logic [3:0]            EXE_memOp_i,
   input  logic [DATA_W-1:0]     EXE_rtData_i,
   input  logic [DATA_W-1:0]     EXE_finalRes_i,
   input  logic                  EXE_exceptionRisk_i,
   input  logic                  EXE_isDangerous_i,
   output logic [4:0]            MEM_writeNum_o,
   output logic [ADDR_W-1:0]     MEM_VAddr_o,
   output logic [DATA_W-1:0]     MEM_rtData_o,
   output logic [DATA_W-1:0]     MEM_finalRes_o,
   output logic                  MEM_isDangerous_o,
   output logic                  MEM_exceptionRisk_o,
   output logic                  MEM_memReq_o,
   output logic [1:0]            MEM_alignCheck_o,
   output logic [LOAD_SEL_W-1:0] MEM_loadSel_o,
   output logic                  MEM_addrErr_w_o,
   output logic [ADDR_W-1:0]     MEM_badVAddr_w_o,
   output logic [4:0]            MEM_writeNum_w_o,
   output logic                  data_req,
   output logic                  data_wr,
   output logic [1:0]            data_size,
   output logic [ADDR_W-1:0]     data_addr,
   output logic [3:0]            data_wstrb,
   output logic [DATA_W-1:0]     data_wdata,
   input  logic                  data_addr_ok,
   output logic [1:0]            state_dbg
);

   // Handshake: an entry enters on EXE_valid_w_i & MEM_allowin_w_o and leaves
   // to WB on MEM_valid_w_o & WB_allowin_w_i. The bus accepts a request on
   // data_req & data_addr_ok; data_req is gated by WB_allowin_w_i so that the
   // accept cycle is always the transfer cycle. data_req may drop unaccepted.

   logic                  has_data;
   mem_state_e            state;
   logic [4:0]            write_num_r;
   logic [ADDR_W-1:0]     vaddr_r;
   logic [ADDR_W-1:0]     mem_addr_r;
   mem_op_e               mem_op_r;
   logic [DATA_W-1:0]     rt_data_r;
   logic [DATA_W-1:0]     final_res_r;
   logic                  exc_risk_r;
   logic                  is_dangerous_r;

   logic                  addr_err_s;
   logic [3:0]            wstrb_s;
   logic [31:0]           wdata_s;
   logic [1:0]            size_s;
   logic [LOAD_SEL_W-1:0] load_sel_s;

   mem_op_e               in_op;
   logic                  in_need;
   logic                  held_err;
   logic                  need_req;

   mem_store_align u_align (
      .op      (mem_op_r),
      .a       (mem_addr_r[1:0]),
      .rt      (rt_data_r),
      .wstrb   (wstrb_s),
      .wdata   (wdata_s),
      .size    (size_s),
      .addrErr (addr_err_s),
      .loadSel (load_sel_s)
   );

   assign in_op   = mem_op_e'(EXE_memOp_i);
   assign in_need = (in_op != MEM_OP_NONE) && !EXE_exceptionRisk_i &&
                    !addr_err(in_op, EXE_memAddr_i[1:0]);

   assign held_err = has_data & addr_err_s;
   assign need_req = has_data && (mem_op_r != MEM_OP_NONE) && !exc_risk_r &&
                     !addr_err_s && !flush_w_i;

   assign data_req        = (state == ST_REQ) && need_req && WB_allowin_w_i;
   assign MEM_valid_w_o   = has_data && (!need_req || data_addr_ok || (state == ST_DONE));
   assign MEM_allowin_w_o = !has_data || (MEM_valid_w_o && WB_allowin_w_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         has_data       <= 1'b0;
         state          <= ST_IDLE;
         write_num_r    <= '0;
         vaddr_r        <= '0;
         mem_addr_r     <= '0;
         mem_op_r       <= MEM_OP_NONE;
         rt_data_r      <= '0;
         final_res_r    <= '0;
         exc_risk_r     <= 1'b0;
         is_dangerous_r <= 1'b0;
      end else if (flush_w_i) begin
         has_data <= 1'b0;
         state    <= ST_IDLE;
      end else if (MEM_allowin_w_o) begin
         if (EXE_valid_w_i) begin
            has_data       <= 1'b1;
            state          <= in_need ? ST_REQ : ST_IDLE;
            write_num_r    <= EXE_writeNum_i;
            vaddr_r        <= EXE_VAddr_i;
            mem_addr_r     <= EXE_memAddr_i;
            mem_op_r       <= in_op;
            rt_data_r      <= EXE_rtData_i;
            final_res_r    <= EXE_finalRes_i;
            exc_risk_r     <= EXE_exceptionRisk_i;
            is_dangerous_r <= EXE_isDangerous_i;
         end else begin
            has_data <= 1'b0;
            state    <= ST_IDLE;
         end
      end else if (data_req && data_addr_ok) begin
         state <= ST_DONE;
      end
   end

   assign MEM_writeNum_o      = write_num_r;
   assign MEM_VAddr_o         = vaddr_r;
   assign MEM_rtData_o        = rt_data_r;
   assign MEM_finalRes_o      = final_res_r;
   assign MEM_isDangerous_o   = is_dangerous_r;
   assign MEM_exceptionRisk_o = exc_risk_r | held_err;
   assign MEM_memReq_o        = has_data & is_load(mem_op_r) & !exc_risk_r & !addr_err_s;
   assign MEM_alignCheck_o    = mem_addr_r[1:0];
   assign MEM_loadSel_o       = load_sel_s;
   assign MEM_addrErr_w_o     = held_err;
   assign MEM_badVAddr_w_o    = mem_addr_r;
   assign MEM_writeNum_w_o    = has_data ? write_num_r : 5'd0;

   // Partial-word ops always move the whole aligned word.
   assign data_wr    = is_store(mem_op_r);
   assign data_size  = size_s;
   assign data_addr  = is_partial_word(mem_op_r) ? {mem_addr_r[ADDR_W-1:2], 2'b00} : mem_addr_r;
   assign data_wstrb = wstrb_s;
   assign data_wdata = wdata_s;
   assign state_dbg  = state;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases with literal expectations, then
// randomized traffic checked each cycle against a behavioural model.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        exe_valid = 1'b0;
   logic        wb_allowin = 1'b1;
   logic        mem_allowin, mem_valid;
   logic [4:0]  exe_wn = '0;
   logic [31:0] exe_va = '0, exe_addr = '0, exe_rt = '0, exe_fr = '0;
   logic [3:0]  exe_op = '0;
   logic        exe_risk = 1'b0, exe_dang = 1'b0;
   logic [4:0]  mem_wn, mem_wn_w;
   logic [31:0] mem_va, mem_rt, mem_fr, mem_bad;
   logic        mem_dang, mem_risk, mem_memreq, mem_adderr;
   logic [1:0]  mem_align;
   logic [10:0] mem_lsel;
   logic        data_req, data_wr, data_addr_ok;
   logic [1:0]  data_size, state_dbg;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        ok_en = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   assign data_addr_ok = data_req & ok_en;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk(clk), .rst(rst), .flush_w_i(flush), .EXE_valid_w_i(exe_valid),
      .WB_allowin_w_i(wb_allowin), .MEM_allowin_w_o(mem_allowin), .MEM_valid_w_o(mem_valid),
      .EXE_writeNum_i(exe_wn), .EXE_VAddr_i(exe_va), .EXE_memAddr_i(exe_addr),
      .EXE_memOp_i(exe_op), .EXE_rtData_i(exe_rt), .EXE_finalRes_i(exe_fr),
      .EXE_exceptionRisk_i(exe_risk), .EXE_isDangerous_i(exe_dang),
      .MEM_writeNum_o(mem_wn), .MEM_VAddr_o(mem_va), .MEM_rtData_o(mem_rt),
      .MEM_finalRes_o(mem_fr), .MEM_isDangerous_o(mem_dang), .MEM_exceptionRisk_o(mem_risk),
      .MEM_memReq_o(mem_memreq), .MEM_alignCheck_o(mem_align), .MEM_loadSel_o(mem_lsel),
      .MEM_addrErr_w_o(mem_adderr), .MEM_badVAddr_w_o(mem_bad), .MEM_writeNum_w_o(mem_wn_w),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .state_dbg(state_dbg)
   );

   // Behavioural model: the held entry plus whether its request was accepted.
   logic        m_has = 1'b0, m_acc = 1'b0;
   int          m_op = 0;
   logic [31:0] m_addr = '0, m_rt = '0, m_va = '0, m_fr = '0;
   logic [4:0]  m_wn = '0;
   logic        m_risk = 1'b0, m_dang = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic f_err(int op, logic [1:0] a);
      if (op == 3 || op == 4 || op == 9) return a[0];
      if (op == 5 || op == 10) return a != 2'd0;
      return 1'b0;
   endfunction

   function automatic logic [10:0] f_lsel(int op, logic [1:0] a);
      logic [10:0] one = 11'd1;
      case (op)
         1, 2, 3, 4, 5: return one << (op - 1);
         6: return (a == 2'd3) ? (one << 4) : (one << (5 + int'(a)));
         7: return (a == 2'd0) ? (one << 4) : (one << (7 + int'(a)));
         default: return 11'd0;
      endcase
   endfunction

   function automatic logic [1:0] f_size(int op);
      if (op == 1 || op == 2 || op == 8 || op == 0) return 2'd0;
      if (op == 3 || op == 4 || op == 9) return 2'd1;
      return 2'd2;
   endfunction

   function automatic logic [3:0] f_wstrb(int op, logic [1:0] a);
      logic [4:0] w;
      case (op)
         8:  w = 5'd1 << a;
         9:  w = 5'd3 << (a & 2'd2);
         10: w = 5'hF;
         11: w = (5'd2 << a) - 5'd1;
         12: w = 5'hF << a;
         default: w = 5'd0;
      endcase
      return w[3:0];
   endfunction

   function automatic logic [31:0] f_wdata(int op, logic [1:0] a, logic [31:0] rt);
      logic [7:0]  b = rt[7:0];
      logic [15:0] h = rt[15:0];
      case (op)
         8:  return b * 32'h0101_0101;
         9:  return h * 32'h0001_0001;
         10: return rt;
         11: return rt >> (8 * (3 - int'(a)));
         12: return rt << (8 * int'(a));
         default: return 32'h0;
      endcase
   endfunction

   // Compare every output against the model, then advance the model past the next edge.
   task automatic check_step();
      logic       err, need_fix, need, e_req, ok, e_valid, e_allow, ld;
      logic [1:0] a;
      a        = m_addr[1:0];
      err      = f_err(m_op, a);
      need_fix = m_has && m_op != 0 && !m_risk && !err;
      need     = need_fix && !flush;
      e_req    = need && !m_acc && wb_allowin;
      ok       = e_req && ok_en;
      e_valid  = m_has && (!need || ok || m_acc);
      e_allow  = !m_has || (e_valid && wb_allowin);
      ld       = m_op >= 1 && m_op <= 7;
      chk("allowin", 32'(mem_allowin), 32'(e_allow));
      chk("valid", 32'(mem_valid), 32'(e_valid));
      chk("data_req", 32'(data_req), 32'(e_req));
      chk("writeNum_w", 32'(mem_wn_w), m_has ? 32'(m_wn) : 32'd0);
      chk("memReq", 32'(mem_memreq), 32'(m_has && ld && !m_risk && !err));
      chk("addrErr", 32'(mem_adderr), 32'(m_has && err));
      if (m_has) begin
         chk("writeNum", 32'(mem_wn), 32'(m_wn));
         chk("VAddr", mem_va, m_va);
         chk("rtData", mem_rt, m_rt);
         chk("finalRes", mem_fr, m_fr);
         chk("isDangerous", 32'(mem_dang), 32'(m_dang));
         chk("exceptionRisk", 32'(mem_risk), 32'(m_risk || err));
         chk("alignCheck", 32'(mem_align), 32'(a));
         chk("loadSel", 32'(mem_lsel), 32'(f_lsel(m_op, a)));
         chk("badVAddr", mem_bad, m_addr);
         chk("data_wr", 32'(data_wr), 32'(m_op >= 8 && m_op <= 12));
         chk("data_size", 32'(data_size), 32'(f_size(m_op)));
         chk("data_addr", data_addr, (m_op == 6 || m_op == 7 || m_op == 11 || m_op == 12) ?
                                     (m_addr & ~32'd3) : m_addr);
         chk("data_wstrb", 32'(data_wstrb), 32'(f_wstrb(m_op, a)));
         chk("data_wdata", data_wdata, f_wdata(m_op, a, m_rt));
      end
      if (flush) begin
         m_has = 1'b0;
         m_acc = 1'b0;
      end else if (e_allow) begin
         m_has = exe_valid;
         m_acc = 1'b0;
         if (exe_valid) begin
            m_op = int'(exe_op); m_addr = exe_addr; m_rt = exe_rt; m_va = exe_va;
            m_fr = exe_fr; m_wn = exe_wn; m_risk = exe_risk; m_dang = exe_dang;
         end
      end else if (ok) begin
         m_acc = 1'b1;
      end
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic advance();
      check_step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      settle();
      advance();
   endtask

   task automatic drive_idle();
      exe_valid = 1'b0; flush = 1'b0; wb_allowin = 1'b1; ok_en = 1'b1; exe_risk = 1'b0;
   endtask

   task automatic load_one(input int op, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [4:0] wn);
      exe_valid = 1'b1; exe_op = 4'(op); exe_addr = addr; exe_rt = rt; exe_wn = wn;
      exe_va = 32'hBFC0_0000 + addr; exe_fr = ~addr; exe_risk = 1'b0; exe_dang = 1'b0;
      flush = 1'b0;
      tick();
      exe_valid = 1'b0;
   endtask

   initial begin
      int n_req, n_val, val_at;
      drive_idle();
      rst = 1'b1;
      #12;
      // Reset state
      chk("rst_allowin", 32'(mem_allowin), 32'd1);
      chk("rst_valid", 32'(mem_valid), 32'd0);
      chk("rst_data_req", 32'(data_req), 32'd0);
      chk("rst_data_wr", 32'(data_wr), 32'd0);
      chk("rst_wstrb", 32'(data_wstrb), 32'd0);
      chk("rst_loadSel", 32'(mem_lsel), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();

      // LW with two cycles of back-pressure on the bus
      ok_en = 1'b0;
      load_one(5, 32'h0000_1000, 32'h0, 5'd3);
      n_req = 0; n_val = 0; val_at = -1;
      for (int i = 0; i < 3; i++) begin
         ok_en = (i == 2);
         settle();
         if (data_req) n_req++;
         if (mem_valid) begin n_val++; val_at = i; end
         if (i == 0) begin
            chk("lw_loadSel", 32'(mem_lsel), 32'h010);
            chk("lw_memReq", 32'(mem_memreq), 32'd1);
            chk("lw_addr", data_addr, 32'h0000_1000);
         end
         advance();
      end
      chk("lw_req_cycles", 32'(n_req), 32'd3);
      chk("lw_valid_cycles", 32'(n_val), 32'd1);
      chk("lw_valid_when", 32'(val_at), 32'd2);
      settle();
      chk("lw_req_after", 32'(data_req), 32'd0);
      advance();

      // SB at byte 3
      load_one(8, 32'h0000_1003, 32'h0000_00AB, 5'd0);
      settle();
      chk("sb_wstrb", 32'(data_wstrb), 32'h8);
      chk("sb_wdata", data_wdata, 32'hABAB_ABAB);
      chk("sb_size", 32'(data_size), 32'd0);
      chk("sb_wr", 32'(data_wr), 32'd1);
      chk("sb_req", 32'(data_req), 32'd1);
      advance();

      // LWL / LWR word-aligned request
      load_one(6, 32'h0000_2001, 32'h5555_5555, 5'd4);
      settle();
      chk("lwl_addr", data_addr, 32'h0000_2000);
      chk("lwl_size", 32'(data_size), 32'd2);
      chk("lwl_loadSel", 32'(mem_lsel), 32'h040);
      advance();
      load_one(7, 32'h0000_2002, 32'h6666_6666, 5'd4);
      settle();
      chk("lwr_addr", data_addr, 32'h0000_2000);
      chk("lwr_size", 32'(data_size), 32'd2);
      chk("lwr_loadSel", 32'(mem_lsel), 32'h200);
      advance();

      // LH misaligned
      load_one(3, 32'h0000_3001, 32'h0, 5'd6);
      settle();
      chk("lh_addrErr", 32'(mem_adderr), 32'd1);
      chk("lh_excRisk", 32'(mem_risk), 32'd1);
      chk("lh_req", 32'(data_req), 32'd0);
      chk("lh_valid", 32'(mem_valid), 32'd1);
      chk("lh_badVAddr", mem_bad, 32'h0000_3001);
      advance();

      // SWR
      load_one(12, 32'h0000_4001, 32'h1122_3344, 5'd0);
      settle();
      chk("swr_wstrb", 32'(data_wstrb), 32'hE);
      chk("swr_wdata", data_wdata, 32'h2233_4400);
      advance();

      // Flush during an outstanding request
      ok_en = 1'b0;
      load_one(5, 32'h0000_5000, 32'h0, 5'd7);
      flush = 1'b1;
      settle();
      chk("flush_req", 32'(data_req), 32'd0);
      advance();
      flush = 1'b0;
      settle();
      chk("flush_wn_w", 32'(mem_wn_w), 32'd0);
      chk("flush_valid", 32'(mem_valid), 32'd0);
      advance();

      // Async reset in the middle of a request
      load_one(5, 32'h0000_6000, 32'h0, 5'd9);
      settle();
      chk("arst_req_before", 32'(data_req), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_req", 32'(data_req), 32'd0);
      chk("arst_wn_w", 32'(mem_wn_w), 32'd0);
      chk("arst_valid", 32'(mem_valid), 32'd0);
      m_has = 1'b0; m_acc = 1'b0; m_op = 0; m_addr = '0; m_rt = '0; m_va = '0;
      m_fr = '0; m_wn = '0; m_risk = 1'b0; m_dang = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_idle();
      tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         exe_valid  = $urandom_range(0, 9) < 7;
         exe_op     = 4'($urandom_range(0, 12));
         exe_addr   = $urandom;
         exe_rt     = $urandom;
         exe_va     = $urandom;
         exe_fr     = $urandom;
         exe_wn     = 5'($urandom_range(0, 31));
         exe_risk   = $urandom_range(0, 9) == 0;
         exe_dang   = $urandom_range(0, 7) == 0;
         flush      = $urandom_range(0, 19) == 0;
         wb_allowin = $urandom_range(0, 3) != 0;
         ok_en      = $urandom_range(0, 4) < 3;
         tick();
      end
      drive_idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
